// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the PC fetch sequencer: FSM encoding, reset PC,
// sequential step and the NOP word held in an empty IF/ID register.
package pc_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Bundle of ID-stage redirect inputs, instruction-memory handshake and the
// IF/ID register outputs; master is the sequencer, slave its environment.
interface pc_fetch_sequencer_if;

    logic        stall;
    logic        br_valid;
    logic        br_ne;
    logic [31:0] br_diff;
    logic [31:0] br_offset;
    logic [31:0] br_pc;
    logic        jmp_valid;
    logic [25:0] jmp_index;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;

    modport master (
        input  stall, br_valid, br_ne, br_diff, br_offset, br_pc, jmp_valid, jmp_index,
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        output if_valid, if_instr, if_pc, flush
    );

    modport slave (
        output stall, br_valid, br_ne, br_diff, br_offset, br_pc, jmp_valid, jmp_index,
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        input  if_valid, if_instr, if_pc, flush
    );

endinterface

// File: rtl/pc_fetch_sequencer_next_pc_calc.sv
// Combinational redirect decode and next-PC arithmetic (all modulo 2^32).
module pc_fetch_sequencer_next_pc_calc #(
    parameter logic [31:0] PC_STEP = pc_fetch_sequencer_pkg::PC_STEP
) (
    input  logic [31:0] pc_i,
    input  logic        br_valid_i,
    input  logic        br_ne_i,
    input  logic [31:0] br_diff_i,
    input  logic [31:0] br_offset_i,
    input  logic [31:0] br_pc_i,
    input  logic        jmp_valid_i,
    input  logic [25:0] jmp_index_i,
    output logic        br_taken_o,
    output logic        jump_taken_o,
    output logic [31:0] target_o,
    output logic [31:0] pc_plus_o
);

    logic [31:0] seq_pc;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic        br_cond;

    // br_pc carries the jump's own PC when a jump is presented, so its region bits come from there.
    assign seq_pc     = br_pc_i + PC_STEP;
    assign br_target  = seq_pc + (br_offset_i << 2);
    assign jmp_target = {seq_pc[31:28], jmp_index_i, 2'b00};
    assign br_cond    = br_ne_i ? (br_diff_i != 32'd0) : (br_diff_i == 32'd0);

    assign jump_taken_o = jmp_valid_i;
    assign br_taken_o   = br_valid_i && !jmp_valid_i && br_cond;
    assign target_o     = jmp_valid_i ? jmp_target : br_target;
    assign pc_plus_o    = pc_i + PC_STEP;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Architectural PC owner: picks sequential/branch/jump PC, runs the imem
// valid/ready fetch, and registers the IF/ID stage with flush/stall handling.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = pc_fetch_sequencer_pkg::RESET_PC,
    parameter logic [31:0] PC_STEP  = pc_fetch_sequencer_pkg::PC_STEP
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_fetch_sequencer_if.master bus
);

    import pc_fetch_sequencer_pkg::*;

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pending_q;
    logic         if_valid_q;
    logic [31:0]  if_instr_q;
    logic [31:0]  if_pc_q;

    logic         br_taken;
    logic         jump_taken;
    logic [31:0]  target;
    logic [31:0]  pc_d;
    logic         req;
    logic         flush;
    logic         handshake;

    pc_fetch_sequencer_next_pc_calc #(
        .PC_STEP(PC_STEP)
    ) next_pc_calc (
        .pc_i        (pc_q),
        .br_valid_i  (bus.br_valid),
        .br_ne_i     (bus.br_ne),
        .br_diff_i   (bus.br_diff),
        .br_offset_i (bus.br_offset),
        .br_pc_i     (bus.br_pc),
        .jmp_valid_i (bus.jmp_valid),
        .jmp_index_i (bus.jmp_index),
        .br_taken_o  (br_taken),
        .jump_taken_o(jump_taken),
        .target_o    (target),
        .pc_plus_o   (pc_d)
    );

    always_comb begin
        req = 1'b0;
        case (state_q)
            FETCH:   req = !(bus.stall && if_valid_q);
            DRAIN:   req = 1'b1;
            default: req = 1'b0;
        endcase
    end

    assign flush     = (jump_taken || br_taken) && (state_q != BOOT);
    assign handshake = req && bus.imem_ready;

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.flush     = flush;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;

    // A redirect that hits an unaccepted request parks its target until the old address is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pending_q  <= 32'd0;
            if_valid_q <= 1'b0;
            if_instr_q <= NOP_INSTR;
            if_pc_q    <= 32'd0;
        end else begin
            case (state_q)
                BOOT: state_q <= FETCH;
                FETCH: begin
                    if (flush) begin
                        if_valid_q <= 1'b0;
                        if (req && !bus.imem_ready) begin
                            pending_q <= target;
                            state_q   <= DRAIN;
                        end else begin
                            pc_q <= target;
                        end
                    end else if (handshake) begin
                        if_instr_q <= bus.imem_rdata;
                        if_pc_q    <= pc_q;
                        if_valid_q <= 1'b1;
                        pc_q       <= pc_d;
                    end else if (req) begin
                        if_valid_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if_valid_q <= 1'b0;
                    if (bus.imem_ready) begin
                        pc_q    <= flush ? target : pending_q;
                        state_q <= FETCH;
                    end else if (flush) begin
                        pending_q <= target;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboarded bench for pc_fetch_sequencer: directed sequential fetch,
// branch/jump redirects, stalls, memory wait drains, reset and PC wrap.
module tb_pc_fetch_sequencer;

    logic clk = 1'b0;
    logic rst;

    pc_fetch_sequencer_if bus ();

    pc_fetch_sequencer #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (32'd4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] expAddr[$];
    logic [31:0] expIfPc[$];
    logic prevStall   = 1'b0;
    logic prevIfValid = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] instrOf(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'hA5C3_0F1E;
    endfunction

    assign bus.imem_rdata = instrOf(bus.imem_addr);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic pushFetch(input logic [31:0] addr, input logic keep);
        expAddr.push_back(addr);
        if (keep) expIfPc.push_back(addr);
    endtask

    task automatic applyStimulus(input logic st, input logic brV, input logic brNe,
                                 input logic [31:0] diff, input logic [31:0] off,
                                 input logic [31:0] bpc, input logic jV,
                                 input logic [25:0] jIdx, input logic rdy);
        @(posedge clk);
        #1;
        bus.stall      = st;
        bus.br_valid   = brV;
        bus.br_ne      = brNe;
        bus.br_diff    = diff;
        bus.br_offset  = off;
        bus.br_pc      = bpc;
        bus.jmp_valid  = jV;
        bus.jmp_index  = jIdx;
        bus.imem_ready = rdy;
        #1;
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 26'd0, rdy);
    endtask

    // Monitor: every accepted fetch and every newly presented IF/ID entry is popped and compared.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            prevStall   = 1'b0;
            prevIfValid = 1'b0;
        end else begin
            if (bus.imem_req && bus.imem_ready) begin
                if (expAddr.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL fetchAddr: got fetch at %h, expected none", bus.imem_addr);
                end else begin
                    e = expAddr.pop_front();
                    checkOutput("fetchAddr", bus.imem_addr, e);
                end
            end
            if (bus.if_valid && !(prevStall && prevIfValid)) begin
                if (expIfPc.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL ifEntry: got if_pc %h, expected no entry", bus.if_pc);
                end else begin
                    e = expIfPc.pop_front();
                    checkOutput("ifPc", bus.if_pc, e);
                    checkOutput("ifInstr", bus.if_instr, instrOf(e));
                end
            end
            prevStall   = bus.stall;
            prevIfValid = bus.if_valid;
        end
    end

    initial begin
        rst            = 1'b1;
        bus.stall      = 1'b0;
        bus.br_valid   = 1'b0;
        bus.br_ne      = 1'b0;
        bus.br_diff    = 32'd0;
        bus.br_offset  = 32'd0;
        bus.br_pc      = 32'd0;
        bus.jmp_valid  = 1'b1;
        bus.jmp_index  = 26'h40;
        bus.imem_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstIfValid", 32'(bus.if_valid), 32'd0);
        checkOutput("rstIfInstr", bus.if_instr, 32'd0);
        checkOutput("rstIfPc", bus.if_pc, 32'd0);
        checkOutput("rstReq", 32'(bus.imem_req), 32'd0);
        checkOutput("rstFlush", 32'(bus.flush), 32'd0);

        // Boot cycle: a jump presented here must not redirect
        rst = 1'b0;
        #1;
        checkOutput("bootReq", 32'(bus.imem_req), 32'd0);
        checkOutput("bootFlush", 32'(bus.flush), 32'd0);

        idle(1'b1); pushFetch(32'h0, 1'b1);
        checkOutput("seqAddr0", bus.imem_addr, 32'h0);
        checkOutput("ifValidEarly", 32'(bus.if_valid), 32'd0);
        idle(1'b1); pushFetch(32'h4, 1'b1);
        checkOutput("seqAddr4", bus.imem_addr, 32'h4);
        checkOutput("ifValidRise", 32'(bus.if_valid), 32'd1);
        idle(1'b1); pushFetch(32'h8, 1'b1);
        idle(1'b1); pushFetch(32'hC, 1'b1);

        // beq taken: 0x10 + 4 + 3*4 = 0x20
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'd3, 32'h10, 1'b0, 26'd0, 1'b1);
        pushFetch(32'h10, 1'b0);
        checkOutput("beqFlush", 32'(bus.flush), 32'd1);
        idle(1'b1); pushFetch(32'h20, 1'b1);
        checkOutput("beqTarget", bus.imem_addr, 32'h20);
        checkOutput("beqBubble", 32'(bus.if_valid), 32'd0);

        // beq not taken
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd5, 32'd3, 32'h10, 1'b0, 26'd0, 1'b1);
        pushFetch(32'h24, 1'b1);
        checkOutput("beqNtFlush", 32'(bus.flush), 32'd0);
        idle(1'b1); pushFetch(32'h28, 1'b1);
        checkOutput("beqNtAddr", bus.imem_addr, 32'h28);

        // Jump and taken branch together: jump wins
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'd3, 32'h4000_0008, 1'b1, 26'h40, 1'b1);
        pushFetch(32'h2C, 1'b0);
        checkOutput("jmpFlush", 32'(bus.flush), 32'd1);
        idle(1'b1); pushFetch(32'h4000_0100, 1'b1);
        checkOutput("jmpTarget", bus.imem_addr, 32'h4000_0100);

        // Stall for three cycles with a valid IF/ID entry
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 26'd0, 1'b1);
            checkOutput("stallReq", 32'(bus.imem_req), 32'd0);
            checkOutput("stallIfPc", bus.if_pc, 32'h4000_0100);
            checkOutput("stallIfInstr", bus.if_instr, instrOf(32'h4000_0100));
        end
        idle(1'b1); pushFetch(32'h4000_0104, 1'b1);
        checkOutput("stallResume", bus.imem_addr, 32'h4000_0104);

        // Memory not ready; bne redirect to 0x80 during the wait
        idle(1'b0);
        checkOutput("waitReq", 32'(bus.imem_req), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd1, 32'd3, 32'h70, 1'b0, 26'd0, 1'b0);
        checkOutput("bneFlush", 32'(bus.flush), 32'd1);
        for (int i = 0; i < 2; i++) begin
            idle(1'b0);
            checkOutput("drainAddr", bus.imem_addr, 32'h4000_0108);
            checkOutput("drainReq", 32'(bus.imem_req), 32'd1);
            checkOutput("drainIfValid", 32'(bus.if_valid), 32'd0);
        end
        idle(1'b1); pushFetch(32'h4000_0108, 1'b0);
        idle(1'b1); pushFetch(32'h80, 1'b1);
        checkOutput("drainTarget", bus.imem_addr, 32'h80);
        checkOutput("drainDropped", 32'(bus.if_valid), 32'd0);
        idle(1'b1); pushFetch(32'h84, 1'b1);

        // Redirect in DRAIN with ready the same cycle: newest target loads directly
        idle(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h100, 1'b1, 26'h50, 1'b0);
        checkOutput("jmpWaitFlush", 32'(bus.flush), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd7, 32'd1, 32'h200, 1'b0, 26'd0, 1'b1);
        pushFetch(32'h88, 1'b0);
        checkOutput("drainRedirFlush", 32'(bus.flush), 32'd1);
        idle(1'b1); pushFetch(32'h208, 1'b1);
        checkOutput("latestWins", bus.imem_addr, 32'h208);

        // Reset pulsed in the middle of a drain
        idle(1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 26'd0, 1'b0);
        idle(1'b1);
        rst = 1'b1;
        #1;
        checkOutput("midRstReq", 32'(bus.imem_req), 32'd0);
        checkOutput("midRstIfValid", 32'(bus.if_valid), 32'd0);
        checkOutput("midRstIfPc", bus.if_pc, 32'd0);
        checkOutput("midRstIfInstr", bus.if_instr, 32'd0);
        checkOutput("midRstAddr", bus.imem_addr, 32'd0);
        idle(1'b1);
        rst = 1'b0;
        #1;
        checkOutput("postRstBootReq", 32'(bus.imem_req), 32'd0);
        idle(1'b1); pushFetch(32'h0, 1'b1);
        checkOutput("postRstAddr", bus.imem_addr, 32'h0);
        idle(1'b1); pushFetch(32'h4, 1'b1);

        // Jump to the top word, then wrap to zero
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFF0, 1'b1, 26'h3FF_FFFF, 1'b1);
        pushFetch(32'h8, 1'b0);
        idle(1'b1); pushFetch(32'hFFFF_FFFC, 1'b1);
        checkOutput("topAddr", bus.imem_addr, 32'hFFFF_FFFC);
        idle(1'b1); pushFetch(32'h0, 1'b1);
        checkOutput("wrapAddr", bus.imem_addr, 32'h0);
        idle(1'b0);
        idle(1'b0);
        @(posedge clk);
        #1;

        checkOutput("expAddrLeft", 32'(expAddr.size()), 32'd0);
        checkOutput("expIfLeft", 32'(expIfPc.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
